// File: rtl/calib_update_sequencer.sv
// calib_update_sequencer: shadowed pixel/filter calibration, committed at frame_end via load_req/load_ack.
// Define LOAD_TIMEOUT_EN to add a load_ack timeout with a sticky load_err output.
module calib_update_sequencer #(
  parameter int PIX_W        = 8,
  parameter int FILT_W       = 4,
  parameter int PIX_DEFAULT  = 128,
  parameter int FILT_DEFAULT = 3,
  parameter int PIX_STEP     = 4,
  parameter int FILT_MAX     = 7,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_pixel_add,
  input  logic              enable_pixel_sub,
  input  logic              enable_filter_add,
  input  logic              enable_filter_sub,
  input  logic              reset_pixel,
  input  logic              reset_filter,
  input  logic              auto_valid,
  input  logic [PIX_W-1:0]  auto_pixel,
  output logic              auto_ready,
  input  logic              frame_end,
  output logic              load_req,
  input  logic              load_ack,
  output logic [PIX_W-1:0]  pixel_thresh,
  output logic [FILT_W-1:0] filter_size,
  output logic              pending,
  output logic              busy
`ifdef LOAD_TIMEOUT_EN
  , output logic            load_err
`endif
);
  localparam logic [PIX_W-1:0]  PDEF  = PIX_W'(PIX_DEFAULT);
  localparam logic [PIX_W:0]    PSTEP = (PIX_W+1)'(PIX_STEP);
  localparam logic [FILT_W-1:0] FDEF  = FILT_W'(FILT_DEFAULT);
  localparam logic [FILT_W:0]   FMAX  = (FILT_W+1)'(FILT_MAX);
  localparam logic [FILT_W-1:0] FONE  = FILT_W'(1);

  typedef enum logic [1:0] {IDLE, ARMED, LOAD} state_t;
  state_t state, state_n;

  logic [PIX_W-1:0]  pix_sh, pix_c, pix_n;
  logic [FILT_W-1:0] filt_sh, filt_c, filt_n;
  logic [PIX_W:0]    pix_add, pix_sub;
  logic [FILT_W:0]   filt_add;
  logic              dirty, auto_acc, pix_op, filt_op, commit, tmo;

  assign auto_ready = ~(enable_pixel_add | enable_pixel_sub | reset_pixel);
  assign auto_acc   = auto_valid & auto_ready;
  assign pix_op     = enable_pixel_add | enable_pixel_sub | reset_pixel | auto_acc;
  assign filt_op    = enable_filter_add | enable_filter_sub | reset_filter;
  assign commit     = (state == ARMED) & frame_end;
  assign pix_add    = {1'b0, pix_sh} + PSTEP;
  assign pix_sub    = {1'b0, pix_sh} - PSTEP;
  assign filt_add   = {1'b0, filt_sh} + 1'b1;

  always_comb begin
    pix_n  = reset_pixel ? PDEF :
             enable_pixel_add ? (pix_add[PIX_W] ? '1 : pix_add[PIX_W-1:0]) :
             enable_pixel_sub ? (pix_sub[PIX_W] ? '0 : pix_sub[PIX_W-1:0]) :
             auto_acc ? auto_pixel : pix_sh;
    filt_n = reset_filter ? FDEF :
             enable_filter_add ? (filt_add > FMAX ? FMAX[FILT_W-1:0] : filt_add[FILT_W-1:0]) :
             enable_filter_sub ? (filt_sh <= FONE ? FONE : filt_sh - FONE) : filt_sh;
  end

`ifdef LOAD_TIMEOUT_EN
  logic [7:0] cnt;
  assign tmo = (state == LOAD) & ~load_ack & (cnt == 8'(TIMEOUT_CYC - 1));
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cnt      <= '0;
      load_err <= 1'b0;
    end else begin
      cnt      <= (state == LOAD) ? cnt + 8'd1 : 8'd0;
      load_err <= load_err | tmo;
    end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = dirty ? ARMED : IDLE;
      ARMED:   state_n = frame_end ? LOAD : ARMED;
      LOAD:    state_n = (load_ack | tmo) ? IDLE : LOAD;
      default: state_n = IDLE;
    endcase
  end

  // A same-cycle op during commit keeps dirty set; a timeout forces a retry.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      pix_sh  <= PDEF;
      filt_sh <= FDEF;
      pix_c   <= PDEF;
      filt_c  <= FDEF;
      dirty   <= 1'b0;
    end else begin
      pix_sh  <= pix_n;
      filt_sh <= filt_n;
      if (commit) begin
        pix_c  <= pix_sh;
        filt_c <= filt_sh;
      end
      dirty <= tmo | pix_op | filt_op | (dirty & ~commit);
    end

  assign pixel_thresh = pix_c;
  assign filter_size  = filt_c;
  assign load_req     = (state == LOAD);
  assign pending      = dirty;
  assign busy         = (state != IDLE);
endmodule

// File: tb/tb_calib_update_sequencer.sv
// tb_calib_update_sequencer: scoreboard of expected commits checked on each load_req rise.
module tb_calib_update_sequencer;
  logic clock, reset;
  logic enable_pixel_add, enable_pixel_sub, enable_filter_add, enable_filter_sub;
  logic reset_pixel, reset_filter, auto_valid, auto_ready, frame_end, load_req, load_ack;
  logic pending, busy;
  logic [7:0] auto_pixel, pixel_thresh;
  logic [3:0] filter_size;
`ifdef LOAD_TIMEOUT_EN
  logic load_err;
`endif
  int n_cmp = 0, n_err = 0;
  logic [11:0] sb[$];
  logic prev_lr = 1'b0;

  calib_update_sequencer dut (
    .clock(clock), .reset(reset),
    .enable_pixel_add(enable_pixel_add), .enable_pixel_sub(enable_pixel_sub),
    .enable_filter_add(enable_filter_add), .enable_filter_sub(enable_filter_sub),
    .reset_pixel(reset_pixel), .reset_filter(reset_filter),
    .auto_valid(auto_valid), .auto_pixel(auto_pixel), .auto_ready(auto_ready),
    .frame_end(frame_end), .load_req(load_req), .load_ack(load_ack),
    .pixel_thresh(pixel_thresh), .filter_size(filter_size),
    .pending(pending), .busy(busy)
`ifdef LOAD_TIMEOUT_EN
    , .load_err(load_err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (load_req && !prev_lr) begin
      if (sb.size() == 0) check("sb_unexpected", 32'(load_req), 32'(0));
      else check("sb_commit", 32'({pixel_thresh, filter_size}), 32'(sb.pop_front()));
    end
    prev_lr <= load_req;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic commit(input logic [7:0] p, input logic [3:0] f);
    step();
    frame_end = 1'b1;
    sb.push_back({p, f});
    step();
    frame_end = 1'b0;
    check("commit_req", 32'(load_req), 32'(1));
    check("commit_pix", 32'(pixel_thresh), 32'(p));
    check("commit_filt", 32'(filter_size), 32'(f));
  endtask

  task automatic ack();
    load_ack = 1'b1;
    step();
    load_ack = 1'b0;
    check("ack_req", 32'(load_req), 32'(0));
  endtask

  initial begin
    reset = 1'b1;
    {enable_pixel_add, enable_pixel_sub, enable_filter_add, enable_filter_sub} = '0;
    {reset_pixel, reset_filter, auto_valid, frame_end, load_ack} = '0;
    auto_pixel = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    step();
    check("rst_pix", 32'(pixel_thresh), 32'(128));
    check("rst_filt", 32'(filter_size), 32'(3));
    check("rst_req", 32'(load_req), 32'(0));
    check("rst_pend", 32'(pending), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_ready", 32'(auto_ready), 32'(1));
`ifdef LOAD_TIMEOUT_EN
    check("rst_err", 32'(load_err), 32'(0));
`endif
    frame_end = 1'b1; step(); frame_end = 1'b0; step();
    check("clean_fe", 32'(load_req), 32'(0));
    load_ack = 1'b1; step(); load_ack = 1'b0;
    check("stray_ack", 32'(busy), 32'(0));
    repeat (3) begin enable_pixel_add = 1'b1; step(); enable_pixel_add = 1'b0; end
    check("add_pend", 32'(pending), 32'(1));
    check("add_frozen", 32'(pixel_thresh), 32'(128));
    commit(8'd140, 4'd3);
    ack();
    check("ack_pend", 32'(pending), 32'(0));
    check("ack_busy", 32'(busy), 32'(0));
    auto_valid = 1'b1; auto_pixel = 8'd254; step(); auto_valid = 1'b0;
    enable_pixel_add = 1'b1; step(); enable_pixel_add = 1'b0;
    repeat (5) begin enable_filter_add = 1'b1; step(); enable_filter_add = 1'b0; end
    repeat (10) begin enable_filter_sub = 1'b1; step(); enable_filter_sub = 1'b0; end
    commit(8'd255, 4'd1);
    ack();
    auto_valid = 1'b1; auto_pixel = 8'd2; step(); auto_valid = 1'b0;
    enable_pixel_sub = 1'b1; step(); enable_pixel_sub = 1'b0;
    commit(8'd0, 4'd1);
    ack();
    reset_pixel = 1'b1; reset_filter = 1'b1; step(); reset_pixel = 1'b0; reset_filter = 1'b0;
    step();
    enable_pixel_sub = 1'b1; auto_valid = 1'b1; auto_pixel = 8'd50;
    #1 check("arb_block", 32'(auto_ready), 32'(0));
    step();
    enable_pixel_sub = 1'b0;
    #1 check("arb_free", 32'(auto_ready), 32'(1));
    frame_end = 1'b1;
    sb.push_back({8'd124, 4'd3});
    step();
    frame_end = 1'b0; auto_valid = 1'b0;
    check("race_pix", 32'(pixel_thresh), 32'(124));
    check("race_pend", 32'(pending), 32'(1));
    ack();
    commit(8'd50, 4'd3);
    enable_filter_add = 1'b1; step(); enable_filter_add = 1'b0;
    check("load_frozen", 32'(filter_size), 32'(3));
    check("load_pend", 32'(pending), 32'(1));
    frame_end = 1'b1; step(); frame_end = 1'b0;
    check("load_fe_req", 32'(load_req), 32'(1));
    check("load_fe_pix", 32'(pixel_thresh), 32'(50));
    ack();
    step();
    check("rearm_busy", 32'(busy), 32'(1));
    commit(8'd50, 4'd4);
    ack();
    check("final_pend", 32'(pending), 32'(0));
`ifdef LOAD_TIMEOUT_EN
    begin
      int n;
      enable_pixel_add = 1'b1; step(); enable_pixel_add = 1'b0;
      commit(8'd54, 4'd4);
      n = 0;
      while (load_req && n < 300) begin step(); n++; end
      check("tmo_cycles", 32'(n), 32'(255));
      check("tmo_err", 32'(load_err), 32'(1));
      check("tmo_pend", 32'(pending), 32'(1));
      commit(8'd54, 4'd4);
      ack();
      check("tmo_sticky", 32'(load_err), 32'(1));
    end
`endif
    step(); step();
    check("sb_drain", 32'(sb.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
